// File: rtl/ext_mem_wait.sv
// ext_mem_wait: single-port word memory behind a fixed-latency request/ready
// handshake. A request is accepted in IDLE. It completes LATENCY cycles later
// with a one-cycle ready_o pulse. Words outside DEPTH complete with err_o set.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | waiting for mem_req_i; accepts on the next rising edge
//   ST_BUSY | transaction captured, counting down to the completion edge
module ext_mem_wait #(
    parameter int DEPTH   = 4096,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        mem_req_i,
    input  logic        write_enable_i,
    input  logic [3:0]  byte_enable_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] write_data_i,
    output logic [31:0] read_data_o,
    output logic        ready_o,
    output logic        err_o,
    output logic        busy_o
);

    localparam int          AW         = $clog2(DEPTH);
    localparam logic [3:0]  CNT_LOAD   = 4'(LATENCY - 1);
    localparam logic [31:0] RST_RDATA  = 32'hfa11_1eaf;
    localparam logic [31:0] OOR_RDATA  = 32'hdead_beef;

    typedef enum logic {
        ST_IDLE,
        ST_BUSY
    } state_t;

    state_t      r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [3:0]  r_be;
    logic [AW-1:0] r_idx;
    logic        r_oor;
    logic [31:0] r_wdata;
    logic [31:0] r_mem [DEPTH];

    logic [29:0] w_word;
    logic        w_oor;
    logic        w_done;
    logic        w_unused;

    // The word index is the byte address with the two lane bits dropped.
    // Anything with bits set above the index width lies beyond the memory.
    assign w_word   = addr_i[31:2];
    assign w_oor    = (w_word[29:AW] != '0);
    assign w_done   = (r_state == ST_BUSY) && (r_cnt == 4'd0);
    assign w_unused = ^addr_i[1:0];

    // Handshake FSM: capture on accept, count down, complete with a ready pulse.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            ready_o     <= 1'b0;
            err_o       <= 1'b0;
            busy_o      <= 1'b0;
            read_data_o <= RST_RDATA;
        end else begin
            ready_o <= 1'b0;
            err_o   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (mem_req_i) begin
                        r_we    <= write_enable_i;
                        r_be    <= byte_enable_i;
                        r_idx   <= w_word[AW-1:0];
                        r_oor   <= w_oor;
                        r_wdata <= write_data_i;
                        r_cnt   <= CNT_LOAD;
                        r_state <= ST_BUSY;
                        busy_o  <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_IDLE;
                        busy_o  <= 1'b0;
                        ready_o <= 1'b1;
                        err_o   <= r_oor;
                        // Writes leave the last read result in place.
                        if (!r_we) begin
                            read_data_o <= r_oor ? OOR_RDATA : r_mem[r_idx];
                        end
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy_o  <= 1'b0;
                end
            endcase
        end
    end

    // Byte-lane write at the completion edge. A reset on that edge cancels it,
    // and the array itself is never cleared.
    always_ff @(posedge clk_i) begin
        if (rst_ni && w_done && r_we && !r_oor) begin
            for (int n = 0; n < 4; n++) begin
                if (r_be[n]) begin
                    r_mem[r_idx][8*n +: 8] <= r_wdata[8*n +: 8];
                end
            end
        end
    end

endmodule

// File: tb/tb_ext_mem_wait.sv
// Bench for ext_mem_wait. Three instances with LATENCY 1, 2 and 3 share the
// data inputs. Each instance has its own request line, and only one instance
// has work outstanding at a time. Expectations are queued at accept time and
// popped by a monitor whenever an instance pulses ready.
module tb_ext_mem_wait;
    localparam int NDUT  = 3;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n;
    logic [NDUT-1:0] req;
    logic            we;
    logic [3:0]      be;
    logic [31:0]     addr;
    logic [31:0]     wdata;
    logic [31:0]     rdata [NDUT];
    logic [NDUT-1:0] ready;
    logic [NDUT-1:0] err;
    logic [NDUT-1:0] busy;

    for (genvar k = 0; k < NDUT; k++) begin : g_dut
        ext_mem_wait #(.DEPTH(DEPTH), .LATENCY(k + 1)) u_dut (
            .clk_i         (clk),
            .rst_ni        (rst_n),
            .mem_req_i     (req[k]),
            .write_enable_i(we),
            .byte_enable_i (be),
            .addr_i        (addr),
            .write_data_i  (wdata),
            .read_data_o   (rdata[k]),
            .ready_o       (ready[k]),
            .err_o         (err[k]),
            .busy_o        (busy[k])
        );
    end

    typedef struct {
        int          dut;
        logic [31:0] data;
        logic [31:0] mask;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] m_data [longint];
    logic [31:0] m_mask [longint];
    logic [31:0] last_rd   [NDUT];
    logic [31:0] last_mask [NDUT];
    int          cyc   = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp, logic [31:0] mask);
        n_cmp++;
        if ((act & mask) !== (exp & mask)) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (mask %h) at cycle %0d", name, act, exp, mask, cyc);
        end
    endfunction

    function automatic logic [31:0] lane_mask(logic [3:0] b);
        logic [31:0] m;
        for (int n = 0; n < 4; n++) m[8*n +: 8] = {8{b[n]}};
        return m;
    endfunction

    function automatic longint mkey(int k, logic [31:0] a);
        return (longint'(k) << 32) | longint'(a[31:2]);
    endfunction

    // Reference model: a per-instance word store with per-byte known masks.
    // Completion time is the accept edge plus LATENCY.
    function automatic void push_exp(int k, logic w, logic [3:0] b, logic [31:0] a, logic [31:0] d);
        exp_t        e;
        longint      key;
        logic [31:0] lm;
        key   = mkey(k, a);
        lm    = lane_mask(b);
        e.dut = k;
        e.cyc = cyc + 1 + (k + 1);
        e.err = (a[31:2] >= 30'(DEPTH));
        if (!m_mask.exists(key)) begin
            m_data[key] = '0;
            m_mask[key] = '0;
        end
        if (w) begin
            if (!e.err) begin
                m_data[key] = (m_data[key] & ~lm) | (d & lm);
                m_mask[key] = m_mask[key] | lm;
            end
            e.data = last_rd[k];
            e.mask = last_mask[k];
        end else begin
            if (e.err) begin
                e.data = 32'hdead_beef;
                e.mask = '1;
            end else begin
                e.data = m_data[key];
                e.mask = m_mask[key];
            end
            last_rd[k]   = e.data;
            last_mask[k] = e.mask;
        end
        sb.push_back(e);
    endfunction

    // Monitor: pop and compare on every ready pulse; flag late or stray pulses.
    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < NDUT; k++) begin
            if (ready[k] === 1'b1) begin
                if (sb.size() == 0 || sb[0].dut != k) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_ready: dut %0d pulsed ready, expected none at cycle %0d", k, cyc);
                end else begin
                    e = sb.pop_front();
                    check("ready_cycle", 32'(cyc), 32'(e.cyc), '1);
                    check("err", {31'd0, err[k]}, {31'd0, e.err}, 32'd1);
                    check("read_data", rdata[k], e.data, e.mask);
                end
            end else if (err[k] !== 1'b0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL err_idle: dut %0d err_o=%b, expected 0 without ready at cycle %0d", k, err[k], cyc);
            end
        end
        if (sb.size() != 0 && sb[0].cyc <= cyc) begin
            n_cmp++;
            n_bad++;
            $display("FAIL missing_ready: dut %0d no ready, expected at cycle %0d (now %0d)", sb[0].dut, sb[0].cyc, cyc);
            void'(sb.pop_front());
        end
    end

    // Present a transaction to instance k until it is taken, scrambling the
    // inputs while the instance is busy. Request stays high afterwards.
    task automatic issue(input int k, input logic w, input logic [3:0] b,
                         input logic [31:0] a, input logic [31:0] d, output int acc_cyc);
        bit idle;
        int tries;
        idle    = 1'b0;
        tries   = 0;
        acc_cyc = -1;
        while (!idle) begin
            @(negedge clk);
            idle   = (busy[k] === 1'b0) && rst_n;
            req    = '0;
            req[k] = 1'b1;
            if (idle) begin
                we      = w;
                be      = b;
                addr    = a;
                wdata   = d;
                acc_cyc = cyc + 1;
                push_exp(k, w, b, a, d);
            end else begin
                we    = 1'($urandom);
                be    = 4'($urandom);
                addr  = $urandom;
                wdata = $urandom;
                tries++;
                if (tries > 50) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL accept_timeout: dut %0d still busy, expected idle within 50 cycles", k);
                    req = '0;
                    return;
                end
            end
        end
        @(posedge clk);
        #1;
        check("busy_after_accept", {31'd0, busy[k]}, 32'd1, 32'd1);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) begin
            @(negedge clk);
            req = '0;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (sb.size() != 0 && t < 40) begin
            @(negedge clk);
            req = '0;
            t++;
        end
        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain_timeout: %0d responses outstanding, expected 0", sb.size());
            sb.delete();
        end
    endtask

    // Two reset edges with requests asserted; none may be taken.
    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req   = '1;
        we    = 1'b1;
        be    = 4'hF;
        addr  = $urandom;
        wdata = $urandom;
        repeat (2) @(negedge clk);
        req   = '0;
        rst_n = 1'b1;
        sb.delete();
        for (int k = 0; k < NDUT; k++) begin
            last_rd[k]   = 32'hfa11_1eaf;
            last_mask[k] = '1;
        end
        @(negedge clk);
        for (int k = 0; k < NDUT; k++) begin
            check("rst_ready", {31'd0, ready[k]}, 32'd0, '1);
            check("rst_busy", {31'd0, busy[k]}, 32'd0, '1);
            check("rst_err", {31'd0, err[k]}, 32'd0, '1);
            check("rst_rdata", rdata[k], 32'hfa11_1eaf, '1);
        end
    endtask

    initial begin
        int          ac;
        int          prev_ac;
        int          prev_k;
        longint      key;
        logic [31:0] s_d;
        logic [31:0] s_m;
        rst_n = 1'b0;
        req   = '0;
        we    = 1'b0;
        be    = 4'h0;
        addr  = '0;
        wdata = '0;
        do_reset();

        // Basic write/read on the LATENCY=2 instance.
        issue(1, 1'b1, 4'hF, 32'h10, 32'h1234_5678, ac);
        issue(1, 1'b0, 4'h0, 32'h10, 32'h0, ac);
        idle_cycles(3);

        // Partial byte-lane write over a known word.
        issue(1, 1'b1, 4'hF, 32'h30, 32'h1122_3344, ac);
        issue(1, 1'b1, 4'b0101, 32'h30, 32'hAABB_CCDD, ac);
        issue(1, 1'b0, 4'h0, 32'h30, 32'h0, ac);
        issue(1, 1'b1, 4'h0, 32'h30, 32'hFFFF_FFFF, ac);
        issue(1, 1'b0, 4'h0, 32'h33, 32'h0, ac);
        idle_cycles(2);

        // Out-of-range read and write; word 0 must survive the write.
        issue(1, 1'b1, 4'hF, 32'h0, 32'hCAFE_F00D, ac);
        issue(1, 1'b0, 4'h0, 32'h4000, 32'h0, ac);
        issue(1, 1'b1, 4'hF, 32'h4000, 32'hFFFF_FFFF, ac);
        issue(1, 1'b0, 4'h0, 32'h0, 32'h0, ac);
        issue(1, 1'b0, 4'h0, 32'h3FFC, 32'h0, ac);
        wait_drain();

        // Back-to-back on LATENCY=1: accepts must land every second edge.
        prev_ac = -1;
        for (int i = 0; i < 30; i++) begin
            logic [31:0] a;
            a = ($urandom_range(0, 9) == 0) ? (32'h4000 | $urandom) : 32'($urandom_range(0, 31));
            issue(0, 1'($urandom), 4'($urandom), a, $urandom, ac);
            if (prev_ac >= 0) check("b2b_spacing", 32'(ac - prev_ac), 32'd2, '1);
            prev_ac = ac;
        end
        wait_drain();

        // Random traffic across all instances with idle gaps.
        prev_k = 0;
        for (int i = 0; i < 45; i++) begin
            int          k;
            logic [31:0] a;
            k = $urandom_range(0, NDUT - 1);
            if (k != prev_k) wait_drain();
            prev_k = k;
            a = ($urandom_range(0, 9) == 0) ? (32'h4000 | $urandom) : 32'($urandom_range(0, 31));
            issue(k, 1'($urandom), 4'($urandom), a, $urandom, ac);
            if ($urandom_range(0, 2) == 0) idle_cycles($urandom_range(1, 4));
        end
        wait_drain();

        // Reset one cycle into a LATENCY=3 write: no pulse, RAM untouched.
        issue(2, 1'b1, 4'hF, 32'h20, 32'h0BAD_F00D, ac);
        wait_drain();
        key = mkey(2, 32'h20);
        s_d = m_data[key];
        s_m = m_mask[key];
        issue(2, 1'b1, 4'hF, 32'h20, 32'hFFFF_FFFF, ac);
        do_reset();
        m_data[key] = s_d;
        m_mask[key] = s_m;
        idle_cycles(4);
        issue(2, 1'b0, 4'h0, 32'h20, 32'h0, ac);
        wait_drain();
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
